// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit single-cycle core.
// Imported by the register file, ALU and decoder.
package cpu_pkg;

  localparam int DATA_W = 16;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef logic [3:0] flags_t;

endpackage

// File: rtl/nzcv_reg.sv
// NZCV status register with load enable.
// The carry tap comes from the register so the ALU carry-in never loops.
module nzcv_reg
  import cpu_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   we,
  input  flags_t d,
  output flags_t q,
  output logic   carry_out
);

  // load new flags on enabled edges, clear on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (we) begin
      q <= d;
    end
  end

  assign carry_out = q[FLAG_C];

endmodule

// File: rtl/reg_file_nzcv.sv
// General-purpose register file plus NZCV status register.
// Two combinational read ports, one write port, optional write forwarding.
module reg_file_nzcv
  import cpu_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int DATA_W   = cpu_pkg::DATA_W,
  parameter bit BYPASS   = 1'b0
)(
  input  logic                        clk,
  input  logic                        rst,
  input  logic [$clog2(NUM_REGS)-1:0] rd_addr_a,
  input  logic [$clog2(NUM_REGS)-1:0] rd_addr_b,
  output logic [DATA_W-1:0]           rd_data_a,
  output logic [DATA_W-1:0]           rd_data_b,
  input  logic                        wr_en,
  input  logic [$clog2(NUM_REGS)-1:0] wr_addr,
  input  logic [DATA_W-1:0]           wr_data,
  input  logic                        flags_we,
  input  flags_t                      flags_in,
  output flags_t                      flags_out,
  output logic                        carry_out
);

  localparam int AW = $clog2(NUM_REGS);

  if (NUM_REGS < 2 || NUM_REGS > 16 ||
      (NUM_REGS & (NUM_REGS - 1)) != 0) begin : g_bad_num_regs
    $error("reg_file_nzcv: NUM_REGS must be a power of two in 2..16");
  end

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              wr_ok;
  logic              hit_a;
  logic              hit_b;

  assign wr_ok = wr_en && (wr_addr != '0);
  assign hit_a = wr_ok && (wr_addr == rd_addr_a);
  assign hit_b = wr_ok && (wr_addr == rd_addr_b);

  // register array; entry 0 is pinned to zero, reset beats writes
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rst || i == 0) begin
        regs[i] <= '0;
      end else if (wr_ok && wr_addr == AW'(i)) begin
        regs[i] <= wr_data;
      end
    end
  end

  // read muxes with R0 forced to zero and optional forwarding
  always_comb begin
    rd_data_a = '0;
    rd_data_b = '0;
    if (rd_addr_a != '0) rd_data_a = regs[rd_addr_a];
    if (rd_addr_b != '0) rd_data_b = regs[rd_addr_b];
    if (BYPASS && hit_a) rd_data_a = wr_data;
    if (BYPASS && hit_b) rd_data_b = wr_data;
  end

  nzcv_reg u_nzcv (
    .clk       (clk),
    .rst       (rst),
    .we        (flags_we),
    .d         (flags_in),
    .q         (flags_out),
    .carry_out (carry_out)
  );

endmodule

// File: tb/tb_reg_file_nzcv.sv
// Directed bench for reg_file_nzcv.
// Runs a BYPASS=0 and a BYPASS=1 instance side by side on shared inputs.
module tb_reg_file_nzcv;

  logic        clk;
  logic        rst;
  logic [2:0]  ra;
  logic [2:0]  rb;
  logic        we;
  logic [2:0]  wa;
  logic [15:0] wd;
  logic        fwe;
  logic [3:0]  fin;

  logic [15:0] a0, b0, a1, b1;
  logic [3:0]  f0, f1;
  logic        c0, c1;

  int total = 0;
  int bad   = 0;

  reg_file_nzcv #(.NUM_REGS(8), .DATA_W(16), .BYPASS(1'b0)) dut0 (
    .clk(clk), .rst(rst),
    .rd_addr_a(ra), .rd_addr_b(rb),
    .rd_data_a(a0), .rd_data_b(b0),
    .wr_en(we), .wr_addr(wa), .wr_data(wd),
    .flags_we(fwe), .flags_in(fin),
    .flags_out(f0), .carry_out(c0)
  );

  reg_file_nzcv #(.NUM_REGS(8), .DATA_W(16), .BYPASS(1'b1)) dut1 (
    .clk(clk), .rst(rst),
    .rd_addr_a(ra), .rd_addr_b(rb),
    .rd_data_a(a1), .rd_data_b(b1),
    .wr_en(we), .wr_addr(wa), .wr_data(wd),
    .flags_we(fwe), .flags_in(fin),
    .flags_out(f1), .carry_out(c1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; we = 0; wa = 0; wd = 0; fwe = 0; fin = 0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    tick();
    tick();
    rst = 0;
    for (int i = 0; i < 8; i++) begin
      ra = 3'(i);
      rb = 3'(7 - i);
      #1;
      total++;
      if (a0 !== 16'h0 || b0 !== 16'h0) begin
        bad++;
        $display("FAIL reset_rd0 addr=%0d got a=%h b=%h exp 0000", i, a0, b0);
      end
      total++;
      if (a1 !== 16'h0 || b1 !== 16'h0) begin
        bad++;
        $display("FAIL reset_rd1 addr=%0d got a=%h b=%h exp 0000", i, a1, b1);
      end
    end
    total++;
    if (f0 !== 4'b0000 || c0 !== 1'b0 || f1 !== 4'b0000 || c1 !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags got f=%b c=%b exp 0000 0", f0, c0);
    end
  endtask

  task automatic test_write_read();
    idle();
    we = 1; wa = 3; wd = 16'hBEEF;
    tick();
    idle();
    ra = 3; rb = 3;
    #1;
    total++;
    if (a0 !== 16'hBEEF || b0 !== 16'hBEEF) begin
      bad++;
      $display("FAIL wr_r3 got a=%h b=%h exp beef", a0, b0);
    end
    total++;
    if (a1 !== 16'hBEEF || b1 !== 16'hBEEF) begin
      bad++;
      $display("FAIL wr_r3_byp got a=%h b=%h exp beef", a1, b1);
    end
    for (int i = 0; i < 8; i++) begin
      if (i == 3) continue;
      ra = 3'(i);
      rb = 3'(i);
      #1;
      total++;
      if (a0 !== 16'h0 || b1 !== 16'h0) begin
        bad++;
        $display("FAIL wr_other addr=%0d got %h/%h exp 0000", i, a0, b1);
      end
    end
  endtask

  task automatic test_r0();
    idle();
    we = 1; wa = 0; wd = 16'h1234;
    ra = 0; rb = 0;
    #1;
    total++;
    if (a1 !== 16'h0 || b1 !== 16'h0) begin
      bad++;
      $display("FAIL r0_fwd got a=%h b=%h exp 0000", a1, b1);
    end
    tick();
    idle();
    #1;
    total++;
    if (a0 !== 16'h0 || b0 !== 16'h0 || a1 !== 16'h0) begin
      bad++;
      $display("FAIL r0_write got a=%h b=%h exp 0000", a0, b0);
    end
  endtask

  task automatic test_bypass();
    idle();
    we = 1; wa = 5; wd = 16'h0001;
    tick();
    we = 1; wa = 5; wd = 16'h00FF;
    ra = 5; rb = 3;
    #1;
    total++;
    if (a0 !== 16'h0001) begin
      bad++;
      $display("FAIL rdw_old got %h exp 0001", a0);
    end
    total++;
    if (a1 !== 16'h00FF) begin
      bad++;
      $display("FAIL rdw_fwd_a got %h exp 00ff", a1);
    end
    total++;
    if (b1 !== 16'hBEEF) begin
      bad++;
      $display("FAIL rdw_nohit_b got %h exp beef", b1);
    end
    ra = 3; rb = 5;
    #1;
    total++;
    if (b1 !== 16'h00FF || b0 !== 16'h0001) begin
      bad++;
      $display("FAIL rdw_port_b got %h/%h exp 00ff/0001", b1, b0);
    end
    tick();
    idle();
    wd = 16'h5555; wa = 5;
    ra = 5; rb = 5;
    #1;
    total++;
    if (a0 !== 16'h00FF || b0 !== 16'h00FF) begin
      bad++;
      $display("FAIL rdw_next got %h exp 00ff", a0);
    end
    total++;
    if (a1 !== 16'h00FF) begin
      bad++;
      $display("FAIL rdw_noen got %h exp 00ff", a1);
    end
  endtask

  task automatic test_flags();
    idle();
    fwe = 1; fin = 4'b0010;
    #1;
    total++;
    if (f0 !== 4'b0000 || c0 !== 1'b0 || c1 !== 1'b0) begin
      bad++;
      $display("FAIL flag_early got f=%b c=%b exp 0000 0", f0, c0);
    end
    tick();
    fwe = 0; fin = 4'b1101;
    #1;
    total++;
    if (f0 !== 4'b0010 || c0 !== 1'b1 || f1 !== 4'b0010) begin
      bad++;
      $display("FAIL flag_load got f=%b c=%b exp 0010 1", f0, c0);
    end
    tick();
    total++;
    if (f0 !== 4'b0010 || c0 !== 1'b1) begin
      bad++;
      $display("FAIL flag_hold got f=%b c=%b exp 0010 1", f0, c0);
    end
    fwe = 1; fin = 4'b1000;
    we = 0; wa = 3; wd = 16'hFFFF;
    tick();
    idle();
    ra = 3; rb = 5;
    #1;
    total++;
    if (f0 !== 4'b1000 || c0 !== 1'b0) begin
      bad++;
      $display("FAIL cmp_flags got f=%b c=%b exp 1000 0", f0, c0);
    end
    total++;
    if (a0 !== 16'hBEEF || b0 !== 16'h00FF) begin
      bad++;
      $display("FAIL cmp_regs got %h/%h exp beef/00ff", a0, b0);
    end
  endtask

  task automatic test_both();
    idle();
    we = 1; wa = 7; wd = 16'h7777;
    fwe = 1; fin = 4'b0101;
    tick();
    idle();
    ra = 7; rb = 7;
    #1;
    total++;
    if (a0 !== 16'h7777 || b1 !== 16'h7777) begin
      bad++;
      $display("FAIL both_reg got %h/%h exp 7777", a0, b1);
    end
    total++;
    if (f0 !== 4'b0101 || c0 !== 1'b0) begin
      bad++;
      $display("FAIL both_flags got f=%b c=%b exp 0101 0", f0, c0);
    end
  endtask

  task automatic test_reset_mid();
    idle();
    we = 1; wa = 2; wd = 16'hAAAA;
    fwe = 1; fin = 4'b1111;
    rst = 1;
    tick();
    idle();
    ra = 2; rb = 3;
    #1;
    total++;
    if (a0 !== 16'h0 || a1 !== 16'h0) begin
      bad++;
      $display("FAIL rstmid_r2 got %h/%h exp 0000", a0, a1);
    end
    total++;
    if (f0 !== 4'b0000 || c0 !== 1'b0 || f1 !== 4'b0000) begin
      bad++;
      $display("FAIL rstmid_flags got f=%b c=%b exp 0000 0", f0, c0);
    end
    total++;
    if (b0 !== 16'h0 || b1 !== 16'h0) begin
      bad++;
      $display("FAIL rstmid_r3 got %h/%h exp 0000", b0, b1);
    end
  endtask

  initial begin
    ra = 0; rb = 0;
    idle();
    test_reset();
    test_write_read();
    test_r0();
    test_bypass();
    test_flags();
    test_both();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
